// File: rtl/counter_capture_unit_if.sv
// Capture FIFO drain channel: head entry plus valid/ready handshake.
// The master drives the data and valid; the slave answers with ready.
interface counter_capture_unit_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] cap_data;
   logic             cap_valid;
   logic             cap_ready;

   modport master (
      output cap_data,
      output cap_valid,
      input  cap_ready
   );

   modport slave (
      input  cap_data,
      input  cap_valid,
      output cap_ready
   );
endinterface

// File: rtl/counter_capture_unit.sv
// Watches a free-running counter: wrap and compare pulses, a saturating
// wrap tally, and a strobe-driven capture FIFO drained by valid/ready.
module counter_capture_unit #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [WIDTH-1:0]        counter_in,
   input  logic [WIDTH-1:0]        cmp_value,
   input  logic                    cmp_load,
   input  logic                    capture,
   counter_capture_unit_if.master  cap,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    match,
   output logic                    wrap,
   output logic [WRAP_W-1:0]       wrap_count,
   output logic                    overflow_err,
   input  logic                    err_clear
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0]  r_cnt_q;
   logic              r_en_q;
   logic [WIDTH-1:0]  r_cmp_q;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_match;
   logic              r_wrap;
   logic [WRAP_W-1:0] r_wrap_cnt;
   logic              r_ovf;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_wrap_hit;
   logic w_match_hit;

   assign w_full      = (r_level == LW'(DEPTH));
   assign w_empty     = (r_level == '0);
   assign w_pop       = !w_empty && cap.cap_ready;
   assign w_push      = capture && (!w_full || w_pop);
   assign w_drop      = capture && w_full && !w_pop;
   assign w_wrap_hit  = r_en_q && (r_cnt_q == '1)
                     && (counter_in == '0);
   assign w_match_hit = (counter_in == r_cmp_q)
                     && (counter_in != r_cnt_q);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt_q    <= '0;
         r_en_q     <= 1'b0;
         r_cmp_q    <= '1;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_match    <= 1'b0;
         r_wrap     <= 1'b0;
         r_wrap_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_cnt_q <= counter_in;
         r_en_q  <= enable;
         r_match <= w_match_hit;
         r_wrap  <= w_wrap_hit;
         if (cmp_load)
            r_cmp_q <= cmp_value;
         if (w_wrap_hit && (r_wrap_cnt != '1))
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         // a drop in the same cycle as a clear keeps the flag set
         if (w_drop)
            r_ovf <= 1'b1;
         else if (err_clear)
            r_ovf <= 1'b0;
      end
   end

   // storage needs no reset: level and pointers gate visibility
   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= counter_in;
   end

   assign cap.cap_data  = r_mem[r_rd_ptr];
   assign cap.cap_valid = !w_empty;
   assign fifo_level    = r_level;
   assign match         = r_match;
   assign wrap          = r_wrap;
   assign wrap_count    = r_wrap_cnt;
   assign overflow_err  = r_ovf;
endmodule

// File: tb/tb_counter_capture_unit.sv
// Directed bench for counter_capture_unit: a queue-based model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_counter_capture_unit;
   localparam int WIDTH  = 4;
   localparam int DEPTH  = 4;
   localparam int WRAP_W = 8;

   logic             clock;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] counter_in;
   logic [WIDTH-1:0] cmp_value;
   logic             cmp_load;
   logic             capture;
   logic [2:0]       fifo_level;
   logic             match;
   logic             wrap;
   logic [7:0]       wrap_count;
   logic             overflow_err;
   logic             err_clear;

   counter_capture_unit_if #(.WIDTH(WIDTH)) cap_bus ();

   counter_capture_unit #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .WRAP_W(WRAP_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .counter_in  (counter_in),
      .cmp_value   (cmp_value),
      .cmp_load    (cmp_load),
      .capture     (capture),
      .cap         (cap_bus.master),
      .fifo_level  (fifo_level),
      .match       (match),
      .wrap        (wrap),
      .wrap_count  (wrap_count),
      .overflow_err(overflow_err),
      .err_clear   (err_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // behavioural model
   int  m_q[$];
   int  m_wraps;
   int  m_cmp;
   int  m_prev_cnt;
   bit  m_prev_en;
   bit  m_match;
   bit  m_wrap;
   bit  m_ovf;
   bit  started = 0;

   always @(posedge clock) begin
      if (!reset) begin
         m_q.delete();
         m_wraps    = 0;
         m_cmp      = 15;
         m_prev_cnt = 0;
         m_prev_en  = 0;
         m_match    = 0;
         m_wrap     = 0;
         m_ovf      = 0;
         started    = 1;
      end else begin
         bit pop;
         bit drop;
         m_wrap = m_prev_en && m_prev_cnt == 15 && counter_in == 0;
         if (m_wrap && m_wraps < 255)
            m_wraps++;
         m_match = (counter_in == m_cmp) && (counter_in != m_prev_cnt);
         if (cmp_load)
            m_cmp = cmp_value;
         pop  = (m_q.size() > 0) && cap_bus.cap_ready;
         drop = capture && m_q.size() == DEPTH && !pop;
         if (pop)
            void'(m_q.pop_front());
         if (capture && !drop)
            m_q.push_back(int'(counter_in));
         if (drop)
            m_ovf = 1;
         else if (err_clear)
            m_ovf = 0;
         m_prev_cnt = counter_in;
         m_prev_en  = enable;
      end
   end

   always @(negedge clock) begin
      if (started) begin
         chk("wrap", wrap, m_wrap);
         chk("match", match, m_match);
         chk("wrap_count", wrap_count, m_wraps);
         chk("overflow_err", overflow_err, m_ovf);
         chk("fifo_level", fifo_level, m_q.size());
         chk("cap_valid", cap_bus.cap_valid, m_q.size() > 0);
         if (m_q.size() > 0)
            chk("cap_data", cap_bus.cap_data, m_q[0]);
      end
   end

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic count_to(input int v);
      counter_in = 4'(v);
      step();
   endtask

   int exp_a[4] = '{3, 7, 9, 12};
   int exp_b[3] = '{1, 2, 3};
   int exp_c[4] = '{4, 10, 11, 12};
   int pulses;

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      counter_in = '0;
      cmp_value  = '0;
      cmp_load   = 1'b0;
      capture    = 1'b0;
      err_clear  = 1'b0;
      cap_bus.cap_ready = 1'b0;
      step();
      step();
      chk("rst_level", fifo_level, 0);
      chk("rst_valid", cap_bus.cap_valid, 0);
      chk("rst_wrap_count", wrap_count, 0);
      chk("rst_ovf", overflow_err, 0);

      // idle with enable low
      reset  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         pulses += int'(wrap) + int'(match);
      end
      chk("idle_pulses", pulses, 0);

      // one full count: match at 15, wrap after 0
      enable = 1'b1;
      pulses = 0;
      for (int v = 0; v < 16; v++) begin
         count_to(v);
         pulses += int'(match);
      end
      chk("match_at_15", match, 1);
      chk("match_once", pulses, 1);
      count_to(0);
      chk("wrap_pulse", wrap, 1);
      chk("wrap_count_1", wrap_count, 1);
      count_to(1);
      chk("wrap_one_cycle", wrap, 0);
      for (int w = 0; w < 299; w++) begin
         for (int v = 2; v < 16; v++)
            count_to(v);
         count_to(0);
         count_to(1);
      end
      chk("wrap_saturate", wrap_count, 255);

      // compare at 5, then hold
      cmp_value = 4'd5;
      cmp_load  = 1'b1;
      count_to(2);
      cmp_load  = 1'b0;
      count_to(3);
      count_to(4);
      chk("no_match_4", match, 0);
      count_to(5);
      chk("match_at_5", match, 1);
      enable = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(match);
      end
      chk("hold_no_match", pulses, 0);

      // fill, overflow, drain
      capture = 1'b1;
      for (int i = 0; i < 4; i++)
         count_to(exp_a[i]);
      chk("full_level", fifo_level, 4);
      chk("full_valid", cap_bus.cap_valid, 1);
      count_to(14);
      chk("drop_ovf", overflow_err, 1);
      chk("drop_level", fifo_level, 4);
      capture = 1'b0;
      cap_bus.cap_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pop_data", cap_bus.cap_data, exp_a[i]);
         step();
      end
      chk("drained", cap_bus.cap_valid, 0);

      // full with push+pop, then error clear rules
      cap_bus.cap_ready = 1'b0;
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("clear_alone", overflow_err, 0);
      capture = 1'b1;
      for (int v = 1; v < 5; v++)
         count_to(v);
      cap_bus.cap_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pp_data", cap_bus.cap_data, exp_b[i]);
         count_to(10 + i);
         chk("pp_level", fifo_level, 4);
         chk("pp_no_ovf", overflow_err, 0);
      end
      cap_bus.cap_ready = 1'b0;
      err_clear = 1'b1;
      count_to(13);
      chk("set_wins", overflow_err, 1);
      capture = 1'b0;
      step();
      err_clear = 1'b0;
      chk("clear_after", overflow_err, 0);
      cap_bus.cap_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pp_drain", cap_bus.cap_data, exp_c[i]);
         step();
      end
      cap_bus.cap_ready = 1'b0;

      // build state, then reset mid-operation
      reset = 1'b0;
      step();
      reset  = 1'b1;
      enable = 1'b1;
      count_to(0);
      for (int w = 0; w < 5; w++) begin
         for (int v = 1; v < 16; v++)
            count_to(v);
         count_to(0);
      end
      chk("wraps_5", wrap_count, 5);
      cmp_value = 4'd9;
      cmp_load  = 1'b1;
      step();
      cmp_load = 1'b0;
      enable   = 1'b0;
      capture  = 1'b1;
      count_to(2);
      count_to(4);
      count_to(6);
      capture = 1'b0;
      chk("pre_rst_level", fifo_level, 3);
      reset   = 1'b0;
      capture = 1'b1;
      step();
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_valid", cap_bus.cap_valid, 0);
      chk("mid_rst_wraps", wrap_count, 0);
      chk("mid_rst_match", match, 0);
      chk("mid_rst_wrap", wrap, 0);
      reset = 1'b1;
      cap_bus.cap_ready = 1'b1;
      count_to(7);
      capture = 1'b0;
      cap_bus.cap_ready = 1'b0;
      chk("post_rst_level", fifo_level, 1);
      chk("post_rst_data", cap_bus.cap_data, 7);
      enable = 1'b1;
      count_to(8);
      count_to(9);
      chk("cmp_not_9", match, 0);
      count_to(15);
      chk("cmp_back_15", match, 1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
